// File: rtl/alu_shift_sequencer.sv
// Purpose: multi-bit shift controller that drives a 1-bit-per-command ALU one step per clock.
// Latency: count N (legal mode) -> response N+1 cycles after acceptance; count 0 or illegal mode -> 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, result held in DONE until rsp_ready.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready               request handshake; req_mode/req_data/req_count payload
//   rsp_valid/rsp_ready               response handshake; rsp_data/rsp_err payload
//   busy                              high whenever not IDLE (and during reset)
//   alu_opm/alu_cmd/alu_a/alu_b       command and operands to the combinational ALU
//   alu_out                           ALU result, fed back as the next operand
module alu_shift_sequencer #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_mode,
  input  logic [WIDTH-1:0] req_data,
  input  logic [CNT_W-1:0] req_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [6:0]       alu_opm,
  output logic [4:0]       alu_cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out
);

  localparam logic [4:0] CMD_ZERO = 5'b00000;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_STEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [4:0]       shift_cmd;

  // Single-bit shift opcode for the latched mode. Only the fixed-fill and
  // arithmetic shifts are used so the ALU flag register never matters.
  always_comb begin
    shift_cmd = CMD_ZERO;
    case (mode_q)
      3'd0:    shift_cmd = 5'b01010;
      3'd1:    shift_cmd = 5'b01011;
      3'd2:    shift_cmd = 5'b01101;
      3'd3:    shift_cmd = 5'b01110;
      3'd4:    shift_cmd = 5'b01111;
      default: shift_cmd = CMD_ZERO;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    alu_cmd    = CMD_ZERO;
    alu_a      = '0;

    case (state_q)
      // One ZERO command flushes the ALU's first-evaluation flag output.
      S_INIT: state_d = S_IDLE;

      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          work_d = req_data;
          cnt_d  = req_count;
          mode_d = req_mode;
          if (req_mode > 3'd4) begin
            rsp_data_d = req_data;
            rsp_err_d  = 1'b1;
            state_d    = S_DONE;
          end else if (req_count == '0) begin
            rsp_data_d = req_data;
            rsp_err_d  = 1'b0;
            state_d    = S_DONE;
          end else begin
            state_d = S_STEP;
          end
        end
      end

      S_STEP: begin
        alu_a   = work_q;
        alu_cmd = shift_cmd;
        work_d  = alu_out;
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          rsp_data_d = alu_out;
          rsp_err_d  = 1'b0;
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end

      default: state_d = S_INIT;
    endcase

    // Handshake outputs are forced inactive while reset is held, whatever
    // state the register happens to hold before the first reset edge.
    if (rst) begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT;
      work_q     <= '0;
      cnt_q      <= '0;
      mode_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign alu_opm  = 7'd0;
  assign alu_b    = '0;

endmodule

// File: tb/tb_alu_shift_sequencer.sv
module tb_alu_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_mode = '0;
  logic [63:0] req_data = '0;
  logic [5:0]  req_count = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic [6:0]  alu_opm;
  logic [4:0]  alu_cmd;
  logic [63:0] alu_a, alu_b, alu_out;

  int asserts = 0;
  int fails = 0;
  int mon_bad = 0;
  int cmd_bad = 0;
  int shift_cnt = 0;
  logic [4:0] exp_cmd = 5'b01010;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [2:0]  mode;
    logic [63:0] data;
    logic [5:0]  count;
    logic [63:0] res;
    logic        err;
    int          lat;
    int          shifts;
    logic [4:0]  cmd;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  alu_shift_sequencer #(.WIDTH(64), .CNT_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .alu_opm(alu_opm), .alu_cmd(alu_cmd), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out)
  );

  // Behavioural model of the one-bit-shift ALU.
  always_comb begin
    case (alu_cmd)
      5'b01010: alu_out = alu_a >> 1;
      5'b01011: alu_out = {1'b1, alu_a[63:1]};
      5'b01101: alu_out = {alu_a[63], alu_a[63:1]};
      5'b01110: alu_out = alu_a << 1;
      5'b01111: alu_out = {alu_a[62:0], 1'b1};
      default:  alu_out = 64'd0;
    endcase
  end

  // Continuous watch on the ALU side: forbidden opcodes, constant operands,
  // zero operand outside shifting, and shift opcode matching the request.
  always @(negedge clk) begin
    if (!rst) begin
      if (alu_opm !== 7'd0 || alu_b !== 64'd0) mon_bad++;
      if (alu_cmd inside {5'b00010, 5'b00011, 5'b01100, 5'b10000}) mon_bad++;
      if (alu_cmd == 5'b00000 && alu_a !== 64'd0) mon_bad++;
      if (alu_cmd != 5'b00000) begin
        shift_cnt++;
        if (alu_cmd !== exp_cmd) cmd_bad++;
      end
    end
  end

  function automatic logic [63:0] shift_ref(input logic [2:0] m, input logic [63:0] d, input int c);
    logic [63:0] r = d;
    if (m > 3'd4) return d;
    for (int i = 0; i < c; i++) begin
      case (m)
        3'd0:    r = r >> 1;
        3'd1:    r = {1'b1, r[63:1]};
        3'd2:    r = {r[63], r[63:1]};
        3'd3:    r = r << 1;
        default: r = {r[62:0], 1'b1};
      endcase
    end
    return r;
  endfunction

  // Present a request (caller is on a falling edge) and hold it until taken.
  // Returns on the falling edge of the cycle after acceptance.
  task automatic issue(input logic [2:0] m, input logic [63:0] d, input logic [5:0] c,
                       output bit ok, output int waits);
    waits = 0;
    req_mode = m; req_data = d; req_count = c; req_valid = 1'b1;
    while (!req_ready && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    ok = req_ready;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Wait for the response (lat counts cycles since acceptance), optionally
  // stall it for hold cycles, then complete the handshake.
  task automatic collect(input int hold, output logic [63:0] d, output logic e,
                         output int lat, output bit to, output bit stable);
    lat = 1;
    stable = 1'b1;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    to = !rsp_valid;
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d || rsp_err !== e || req_ready) stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    asserts++; if (req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL reset_hold: ready=%b busy=%b valid=%b, need 0 1 0", req_ready, busy, rsp_valid); fails++; end
    rst = 1'b0;
    #1;
    asserts++; if (alu_cmd !== 5'b00000 || busy !== 1'b1 || req_ready !== 1'b0) begin
      $display("FAIL init_cycle: cmd=%b busy=%b ready=%b, need 00000 1 0", alu_cmd, busy, req_ready); fails++; end
    @(negedge clk);
    asserts++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL idle_after_init: ready=%b busy=%b, need 1 0", req_ready, busy); fails++; end
    asserts++; if (rsp_data !== 64'd0 || rsp_err !== 1'b0) begin
      $display("FAIL reset_rsp: data=%h err=%b, need 0 0", rsp_data, rsp_err); fails++; end
  endtask

  task automatic test_vectors();
    bit ok, to, st; int w, lat; logic [63:0] d; logic e; exp_t x;
    vt[0] = '{3'd0, 64'h8000_0000_0000_00F0, 6'd4,  64'h0800_0000_0000_000F, 1'b0, 5,  4,  5'b01010};
    vt[1] = '{3'd2, 64'h8000_0000_0000_0000, 6'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64, 63, 5'b01101};
    vt[2] = '{3'd3, 64'h8000_0000_0000_0000, 6'd1,  64'h0,                   1'b0, 2,  1,  5'b01110};
    vt[3] = '{3'd4, 64'h0,                   6'd8,  64'h0000_0000_0000_00FF, 1'b0, 9,  8,  5'b01111};
    vt[4] = '{3'd0, 64'h1234,                6'd0,  64'h1234,                1'b0, 1,  0,  5'b01010};
    vt[5] = '{3'd6, 64'hDEAD_BEEF_0BAD_F00D, 6'd5,  64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1,  0,  5'b01010};
    for (int i = 0; i < 6; i++) begin
      exp_cmd = vt[i].cmd;
      shift_cnt = 0;
      sb_q.push_back('{vt[i].res, vt[i].err, vt[i].lat});
      issue(vt[i].mode, vt[i].data, vt[i].count, ok, w);
      collect(0, d, e, lat, to, st);
      x = sb_q.pop_front();
      asserts++; if (!ok || to) begin
        $display("FAIL vec%0d_handshake: accepted=%b timeout=%b, need 1 0", i, ok, to); fails++; end
      asserts++; if (d !== x.data || e !== x.err) begin
        $display("FAIL vec%0d_result: data=%h err=%b, need %h %b", i, d, e, x.data, x.err); fails++; end
      asserts++; if (lat !== x.lat || shift_cnt !== vt[i].shifts) begin
        $display("FAIL vec%0d_timing: latency=%0d shifts=%0d, need %0d %0d", i, lat, shift_cnt, x.lat, vt[i].shifts); fails++; end
    end
  endtask

  task automatic test_backpressure();
    bit ok, to, st; int w, lat; logic [63:0] d; logic e; exp_t x;
    exp_cmd = 5'b01010;
    sb_q.push_back('{64'h0000_0000_0000_003C, 1'b0, 3});
    issue(3'd0, 64'h0000_0000_0000_00F0, 6'd2, ok, w);
    collect(10, d, e, lat, to, st);
    x = sb_q.pop_front();
    asserts++; if (!st || to) begin
      $display("FAIL bp_stable: stable=%b timeout=%b, need 1 0", st, to); fails++; end
    asserts++; if (d !== x.data || e !== x.err || lat !== x.lat) begin
      $display("FAIL bp_result: data=%h err=%b lat=%0d, need %h %b %0d", d, e, lat, x.data, x.err, x.lat); fails++; end
    asserts++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL bp_release: valid=%b ready=%b, need 0 1", rsp_valid, req_ready); fails++; end
    sb_q.push_back('{64'h77, 1'b0, 1});
    issue(3'd1, 64'h77, 6'd0, ok, w);
    collect(0, d, e, lat, to, st);
    x = sb_q.pop_front();
    asserts++; if (!ok || w !== 0 || d !== x.data || lat !== x.lat) begin
      $display("FAIL bp_next_req: ok=%b waits=%0d data=%h lat=%0d, need 1 0 %h %0d", ok, w, d, lat, x.data, x.lat); fails++; end
  endtask

  task automatic test_reset_in_step();
    bit ok, to, st; int w, lat, seen; logic [63:0] d; logic e; exp_t x;
    exp_cmd = 5'b01010;
    issue(3'd0, 64'hFFFF_0000_FFFF_0000, 6'd30, ok, w);
    asserts++; if (busy !== 1'b1 || alu_cmd !== 5'b01010) begin
      $display("FAIL rst_step_entry: busy=%b cmd=%b, need 1 01010", busy, alu_cmd); fails++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    asserts++; if (alu_cmd !== 5'b00000 || req_ready !== 1'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL rst_step_flush: cmd=%b ready=%b busy=%b valid=%b, need 00000 0 1 0", alu_cmd, req_ready, busy, rsp_valid); fails++; end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    asserts++; if (seen !== 0 || req_ready !== 1'b1) begin
      $display("FAIL rst_step_discard: rsp_valid cycles=%0d ready=%b, need 0 1", seen, req_ready); fails++; end
    exp_cmd = 5'b01011;
    sb_q.push_back('{64'hC000_0000_0000_0000, 1'b0, 3});
    issue(3'd1, 64'h0, 6'd2, ok, w);
    collect(0, d, e, lat, to, st);
    x = sb_q.pop_front();
    asserts++; if (!ok || to || d !== x.data || e !== x.err || lat !== x.lat) begin
      $display("FAIL rst_step_fresh: ok=%b to=%b data=%h err=%b lat=%0d, need 1 0 %h %b %0d", ok, to, d, e, lat, x.data, x.err, x.lat); fails++; end
  endtask

  task automatic test_back_to_back();
    bit ok, to, st; int w, lat, c; logic [2:0] m; logic [63:0] d, v; logic e; exp_t x;
    for (int i = 0; i < 10; i++) begin
      m = 3'($urandom_range(0, 7));
      c = $urandom_range(0, 20);
      v = {$urandom, $urandom};
      exp_cmd = (m == 3'd0) ? 5'b01010 : (m == 3'd1) ? 5'b01011 : (m == 3'd2) ? 5'b01101 :
                (m == 3'd3) ? 5'b01110 : 5'b01111;
      rsp_ready = 1'($urandom_range(0, 1));
      sb_q.push_back('{shift_ref(m, v, c), m > 3'd4, (m > 3'd4 || c == 0) ? 1 : c + 1});
      issue(m, v, 6'(c), ok, w);
      collect(0, d, e, lat, to, st);
      x = sb_q.pop_front();
      asserts++; if (!ok || w !== 0 || to || d !== x.data || e !== x.err || lat !== x.lat) begin
        $display("FAIL b2b_%0d: ok=%b waits=%0d to=%b data=%h err=%b lat=%0d, need 1 0 0 %h %b %0d",
                 i, ok, w, to, d, e, lat, x.data, x.err, x.lat); fails++; end
    end
  endtask

  task automatic test_alu_side();
    asserts++; if (mon_bad !== 0) begin
      $display("FAIL alu_port_rules: violations=%0d, need 0", mon_bad); fails++; end
    asserts++; if (cmd_bad !== 0) begin
      $display("FAIL alu_shift_opcode: wrong-opcode cycles=%0d, need 0", cmd_bad); fails++; end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_in_step();
    test_back_to_back();
    test_alu_side();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/alu_shift_sequencer.md
Name: alu_shift_sequencer

Overview:
- Multi-bit shift controller in front of the 64-bit combinational ALU. The ALU shifts only one bit per command.
- Accepts a shift request (mode, operand, count 0..63) over a valid/ready handshake.
- Issues the matching single-bit ALU shift command once per clock, feeding each result back as the next operand.
- Returns the final value over a valid/ready response channel. It is the sole driver of the ALU command/operand inputs.

Parameters:
WIDTH, 64, datapath width; must match the ALU operand width
CNT_W, 6, shift-count width; maximum count is 2^CNT_W-1

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_mode  in  3  0=SHR fill 0, 1=SHR fill 1, 2=SHR arithmetic, 3=SHL fill 0, 4=SHL fill 1, 5..7 illegal
req_data  in  WIDTH  operand to shift
req_count  in  CNT_W  number of one-bit steps
rsp_valid  out  1  result available
rsp_ready  in  1  consumer takes the result
rsp_data  out  WIDTH  shifted result
rsp_err  out  1  request carried an illegal mode
busy  out  1  state != IDLE
alu_opm  out  7  constant 0
alu_cmd  out  5  ALU command
alu_a  out  WIDTH  ALU operand a
alu_b  out  WIDTH  constant 0
alu_out  in  WIDTH  ALU result (combinational from alu_cmd/alu_a)

Behaviour:
- Clock and reset: single clock domain. rst is synchronous and active-high, and overrides everything, including a request in flight.
- State machine states: INIT, IDLE, STEP, DONE.
- Reset values: state=INIT; rsp_valid=0; rsp_data=0; rsp_err=0; internal work=0; cnt=0.
  - During reset and INIT: req_ready=0, busy=1.
- INIT:
  - Lasts exactly one cycle and drives alu_cmd=ZERO (5'b00000).
  - Purpose: flushes the ALU's power-up "return flags on first evaluation" behaviour so later outputs are data.
  - Transitions to IDLE.
- IDLE:
  - Drives req_ready=1 and alu_cmd=ZERO.
  - On req_valid&&req_ready: work<=req_data; cnt<=req_count; mode latched.
  - If mode>4: rsp_data<=req_data, rsp_err<=1, go to DONE.
  - Else if count==0: rsp_data<=req_data, rsp_err<=0, go to DONE.
  - Else: go to STEP.
- STEP:
  - Drives alu_a=work and alu_cmd from the latched mode:
    - mode 0 → 5'b01010
    - mode 1 → 5'b01011
    - mode 2 → 5'b01101
    - mode 3 → 5'b01110
    - mode 4 → 5'b01111
  - Each edge: work<=alu_out; cnt<=cnt-1.
  - When cnt==1 at the edge: rsp_data<=alu_out, rsp_err<=0, go to DONE.
  - req_ready=0 throughout; new requests are not sampled.
- DONE:
  - Drives rsp_valid=1 and alu_cmd=ZERO. rsp_data/rsp_err stay stable while rsp_valid&&!rsp_ready.
  - On rsp_ready: rsp_valid drops next cycle and state goes to IDLE.
  - A new request is therefore accepted no earlier than the cycle after the response handshake.
- Commands never issued: PASSFLAG (5'b00010), LOADFLAG (5'b00011) and the flag-dependent shifts (5'b01100, 5'b10000). The ALU flag register is never intentionally modified.
- Latency: a request accepted in cycle t with count N (1..63, legal mode) gives rsp_valid high in cycle t+1+N. Count 0 or illegal mode gives rsp_valid in cycle t+1.
- alu_a=0 in all states except STEP.
- Reset in STEP or DONE: the result is discarded, no response is produced, and state goes to INIT (one flush cycle, then IDLE).
- rsp_ready asserted while rsp_valid=0 is ignored. req_valid outside IDLE is ignored; the requester must hold the request until req_ready.

Test Plan:
- Reset release → one cycle with alu_cmd=00000, busy=1, req_ready=0; req_ready=1 in the following cycle.
- mode0, data=64'h8000_0000_0000_00F0, count=4 → rsp_data=64'h0800_0000_0000_000F, rsp_err=0, rsp_valid exactly 5 cycles after acceptance; alu_cmd=01010 for exactly 4 cycles.
- mode2, data=64'h8000_0000_0000_0000, count=63 → rsp_data=64'hFFFF_FFFF_FFFF_FFFF. Same operand with mode3, count=1 → 0. mode4, data=0, count=8 → 64'h0000_0000_0000_00FF.
- count=0, data=64'h1234 → rsp_data=64'h1234 one cycle after acceptance, with no shift command issued. mode=6 → rsp_data=req_data, rsp_err=1.
- Back-pressure: hold rsp_ready=0 for 10 cycles in DONE → rsp_data stable and req_ready=0; release → IDLE next cycle, next request accepted.
- Assert rst during STEP at count=30 → no rsp_valid, INIT flush cycle, then a fresh mode1, data=0, count=2 request yields 64'hC000_0000_0000_0000.
